imu_frame_assembler: RTL and testbench
======================================

Name: imu_frame_assembler

Overview:
- Sits directly downstream of the I2C master.
- Consumes the master's received byte stream (byte plus one-cycle valid strobe) from a burst read of the IMU data registers.
- Packs big-endian byte pairs into signed 16-bit words and publishes one complete, atomically updated sensor frame (accel XYZ, temperature, gyro XYZ) to the attitude-estimation logic.
- Guards against truncated or stalled transfers with a resync input and an inactivity timeout.

Parameters:
- NUM_WORDS, 7, number of 16-bit words per frame: ax, ay, az, temp, gx, gy, gz, in that order.
- TIMEOUT_CYCLES, 50000, clk cycles without an accepted byte before an open frame is abandoned (1 ms at 50 MHz).
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- byte_in  in  8  received byte from the I2C master
- byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle
- frame_start  in  1  one-cycle strobe from the master; the next data phase begins (repeated start plus address accepted)
- accel_x, accel_y, accel_z  out  16 each  signed, last committed frame
- temp_raw  out  16  signed, last committed frame
- gyro_x, gyro_y, gyro_z  out  16 each  signed, last committed frame
- frame_valid  out  1  one-cycle pulse; all seven outputs updated this cycle
- frame_err  out  1  one-cycle pulse; open frame aborted
- busy  out  1  high while a frame is being collected

Behaviour:
- Reset (async, rst_n=0):
  - all word outputs 0; frame_valid=0, frame_err=0, busy=0
  - state IDLE, byte index 0, timeout counter 0
  - shadow buffer contents don't-care
- States:
  - IDLE: frame_start → COLLECT (index=0, counter=0). byte_valid without frame_start is dropped silently, no error.
  - COLLECT: each byte_valid writes byte_in to shadow word[index>>1]. Even index → high byte; odd index → low byte. Then index++.
  - When byte index 2*NUM_WORDS-1 (13) is accepted → COMMIT.
  - COMMIT, one cycle:
    - all seven shadow words copy to the outputs simultaneously
    - frame_valid=1
    - state returns to IDLE
- Latency: outputs and frame_valid appear on the first clk edge after the cycle holding the 14th byte_valid, i.e. 1 cycle.
- Outputs hold the previous committed frame until the next commit. Partial frames are never visible.
- busy=1 in COLLECT and COMMIT, else 0.
- Timeout:
  - counter clears on every accepted byte and on frame_start, and increments each COLLECT cycle otherwise.
  - reaching TIMEOUT_CYCLES-1 → frame_err pulse next cycle, state IDLE, index 0.
- frame_start during COLLECT: current frame aborted, frame_err pulse, restart COLLECT at index 0.
- frame_start and byte_valid in the same cycle:
  - frame_start is applied first; the byte is accepted as index 0.
  - in COLLECT this still raises frame_err if index≠0. With index=0 there is no error.
- frame_start during COMMIT: the commit completes (frame_valid=1), then the block enters COLLECT at index 0 on the same edge. A byte_valid in that same cycle is accepted as index 0.
- byte_valid during COMMIT without frame_start: dropped.
- frame_valid and frame_err never assert in the same cycle.
- Words are signed two's complement; no sign extension or scaling inside this block.
- Reset mid-frame: immediate return to reset state. The committed outputs are cleared to 0.

Decomposition:
- Shared package (imu_pkg):
  - state encoding IDLE/COLLECT/COMMIT
  - word-index constants IDX_AX=0 … IDX_GZ=6
  - NUM_WORDS, and BYTES_PER_FRAME=14
- One sub-module: iic_watchdog, the reloadable timeout counter.
  - inputs: clk, rst_n, clear, enable
  - output: expire pulse

Test Plan:
- Reset then frame_start, 14 bytes 01 02 03 04 … 0D 0E with gaps of 3 cycles → one cycle after the 14th byte: accel_x=0x0102, accel_y=0x0304, accel_z=0x0506, temp_raw=0x0708, gyro_x=0x090A, gyro_y=0x0B0C, gyro_z=0x0D0E. frame_valid high exactly 1 cycle; busy low afterwards.
- Back-to-back frames with byte_valid every cycle; second frame bytes FF 38 … (accel_x=0xFF38 = -200) → two frame_valid pulses; accel_x reads signed -200 after the second; no frame_err.
- frame_start, 5 bytes, then idle 50000 cycles → frame_err pulse at cycle 50000 after the 5th byte; outputs unchanged from the prior frame; busy=0.
- frame_start, 9 bytes, frame_start with byte_valid=AA in the same cycle, then 13 more bytes → frame_err once; committed accel_x high byte = 0xAA; one frame_valid.
- 6 stray byte_valid strobes in IDLE → no output change, no pulses, busy=0.
- rst_n asserted after 10 bytes of a frame → all outputs 0 immediately (asynchronous); next full frame commits correctly.

Source files
------------

// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU frame assembler: FSM encoding,
// frame geometry and the word order of the burst read.
package imu_pkg;

  localparam int NUM_WORDS       = 7;
  localparam int BYTES_PER_FRAME = 2 * NUM_WORDS;
  localparam int IDX_W           = 4;
  localparam int WSEL_W          = IDX_W - 1;

  localparam int IDX_AX   = 0;
  localparam int IDX_AY   = 1;
  localparam int IDX_AZ   = 2;
  localparam int IDX_TEMP = 3;
  localparam int IDX_GX   = 4;
  localparam int IDX_GY   = 5;
  localparam int IDX_GZ   = 6;

  typedef logic [IDX_W-1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/iic_watchdog.sv
// Reloadable inactivity counter: counts enabled, uncleared cycles and
// raises a combinational expire strobe on the last allowed cycle.
module iic_watchdog #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expire = enable && !clear && (cnt_q == LIMIT);

  // Counter parks at zero whenever the owner is not collecting.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !enable || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imu_frame_assembler.sv
// Packs the I2C burst-read byte stream into a seven-word IMU frame and
// publishes it atomically; truncated frames are aborted with frame_err.
module imu_frame_assembler
  import imu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               frame_start,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic signed [15:0] temp_raw,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               busy
);

  state_e            state_q, state_d;
  byte_idx_t         idx_q, idx_d, wr_idx;
  logic              err_q, err_d;
  logic [15:0]       shadow_q    [NUM_WORDS];
  logic [15:0]       words_q     [NUM_WORDS];
  logic [15:0]       commit_word [NUM_WORDS];
  logic              collecting, accept, last_byte, wd_clear, expire;
  logic [WSEL_W-1:0] word_sel;

  // frame_start wins over a coincident byte, which becomes byte 0.
  assign collecting = (state_q == ST_COLLECT);
  assign accept     = byte_valid && (frame_start || collecting);
  assign wr_idx     = frame_start ? '0 : idx_q;
  assign word_sel   = wr_idx[IDX_W-1:1];
  assign last_byte  = accept && (wr_idx == LAST_IDX);
  assign wd_clear   = frame_start || accept;

  iic_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wd_clear),
    .enable(collecting),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    if (frame_start) begin
      state_d = ST_COLLECT;
      idx_d   = byte_valid ? byte_idx_t'(1) : '0;
      err_d   = collecting && (idx_q != '0);
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            if (last_byte) begin
              state_d = ST_COMMIT;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (expire) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            err_d   = 1'b1;
          end
        end
        ST_COMMIT: state_d = ST_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    frame_valid = (state_q == ST_COMMIT);
    busy        = (state_q != ST_IDLE);
    frame_err   = err_q;
  end

  // Shadow buffer carries no reset; only completed frames ever leave it.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (word_sel == WSEL_W'(i)) begin
          if (wr_idx[0]) shadow_q[i][7:0]  <= byte_in;
          else           shadow_q[i][15:8] <= byte_in;
        end
      end
    end
  end

  // The final low byte bypasses the shadow so the commit lands one edge early.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_commit
    if (gi == NUM_WORDS - 1) begin : g_last
      assign commit_word[gi] = {shadow_q[gi][15:8], byte_in};
    end else begin : g_body
      assign commit_word[gi] = shadow_q[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
    end else if (last_byte) begin
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= commit_word[i];
    end
  end

  assign accel_x  = words_q[IDX_AX];
  assign accel_y  = words_q[IDX_AY];
  assign accel_z  = words_q[IDX_AZ];
  assign temp_raw = words_q[IDX_TEMP];
  assign gyro_x   = words_q[IDX_GX];
  assign gyro_y   = words_q[IDX_GY];
  assign gyro_z   = words_q[IDX_GZ];

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a queue-based frame model.
module tb_imu_frame_assembler;

  localparam int T = 50000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              frame_start = 1'b0;
  logic signed [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;
  logic              frame_valid, frame_err, busy;

  always #5 clk = ~clk;

  imu_frame_assembler #(
    .TIMEOUT_CYCLES(T),
    .TO_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_start(frame_start),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_z    (accel_z),
    .temp_raw   (temp_raw),
    .gyro_x     (gyro_x),
    .gyro_y     (gyro_y),
    .gyro_z     (gyro_z),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;

  // Reference model: open frame flag, bytes received so far, idle cycles.
  bit          m_open;
  logic [7:0]  m_q[$];
  int          m_idle;
  logic [15:0] m_words[7];
  bit          m_valid, m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_word(input int w);
    case (w)
      0:       return accel_x;
      1:       return accel_y;
      2:       return accel_z;
      3:       return temp_raw;
      4:       return gyro_x;
      5:       return gyro_y;
      default: return gyro_z;
    endcase
  endfunction

  task automatic check_words(input string tag);
    for (int w = 0; w < 7; w++)
      check_val($sformatf("%s_w%0d", tag, w), 32'(dut_word(w)), 32'(m_words[w]));
  endtask

  function automatic void model_reset();
    m_open = 0;
    m_q.delete();
    m_idle = 0;
    m_valid = 0;
    m_err = 0;
    for (int w = 0; w < 7; w++) m_words[w] = 16'h0000;
  endfunction

  function automatic void model_step(input bit fs, input bit bv, input logic [7:0] b);
    m_valid = 0;
    m_err = 0;
    if (fs) begin
      if (m_open && m_q.size() != 0) m_err = 1;
      m_open = 1;
      m_q.delete();
      m_idle = 0;
    end
    if (m_open && bv) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == 14) begin
        for (int w = 0; w < 7; w++) m_words[w] = {m_q[2*w], m_q[2*w+1]};
        m_valid = 1;
        m_open = 0;
        m_q.delete();
      end
    end else if (m_open && !fs) begin
      m_idle++;
      if (m_idle >= T) begin
        m_err = 1;
        m_open = 0;
        m_q.delete();
        m_idle = 0;
      end
    end
  endfunction

  task automatic tick(input bit fs, input bit bv, input logic [7:0] b);
    frame_start = fs;
    byte_valid  = bv;
    byte_in     = b;
    @(posedge clk);
    model_step(fs, bv, b);
    #1;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    check_val("frame_valid", 32'(frame_valid), 32'(m_valid));
    check_val("frame_err", 32'(frame_err), 32'(m_err));
    check_val("busy", 32'(busy), 32'(m_open || m_valid));
    if (frame_valid) n_valid++;
    if (frame_err) n_err++;
    if (m_valid) begin
      check_words("commit");
      $display("t=%0t commit ax=%h ay=%h az=%h t=%h gx=%h gy=%h gz=%h", $time,
               m_words[0], m_words[1], m_words[2], m_words[3], m_words[4], m_words[5], m_words[6]);
    end
    if (m_err) $display("t=%0t frame aborted", $time);
  endtask

  task automatic check_reset_state(input string tag);
    for (int w = 0; w < 7; w++) check_val($sformatf("%s_w%0d", tag, w), 32'(dut_word(w)), 32'h0);
    check_val({tag, "_valid"}, 32'(frame_valid), 32'h0);
    check_val({tag, "_err"}, 32'(frame_err), 32'h0);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [15:0] exp_tp[7];
    int v0, e0, found;
    bit fs_r, bv_r;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: bytes 01..0E with three idle cycles between bytes.
    exp_tp = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E};
    tick(1, 0, 8'h00);
    for (int i = 0; i < 14; i++) begin
      tick(0, 1, 8'(i + 1));
      if (i != 13) repeat (3) tick(0, 0, 8'h00);
    end
    for (int w = 0; w < 7; w++) check_val($sformatf("tp1_w%0d", w), 32'(dut_word(w)), 32'(exp_tp[w]));
    check_val("tp1_valid", 32'(frame_valid), 32'h1);
    tick(0, 0, 8'h00);
    check_val("tp1_valid_drop", 32'(frame_valid), 32'h0);
    check_val("tp1_busy_after", 32'(busy), 32'h0);

    // Back-to-back frames; second frame starts in the commit cycle.
    v0 = n_valid;
    e0 = n_err;
    tick(1, 0, 8'h00);
    for (int i = 0; i < 14; i++) tick(0, 1, 8'($urandom));
    tick(1, 1, 8'hFF);
    tick(0, 1, 8'h38);
    for (int i = 0; i < 12; i++) tick(0, 1, 8'($urandom));
    check_val("b2b_ax_signed", 32'(int'(accel_x)), 32'(-200));
    tick(0, 0, 8'h00);
    check_val("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    check_val("b2b_err_count", 32'(n_err - e0), 32'd0);

    // Timeout after 5 bytes of an open frame.
    tick(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) tick(0, 1, 8'($urandom));
    found = -1;
    for (int j = 1; j <= T + 10 && found < 0; j++) begin
      tick(0, 0, 8'h00);
      if (frame_err) found = j;
    end
    check_val("timeout_cycle", 32'(found), 32'(T));
    check_words("after_timeout");
    check_val("timeout_busy", 32'(busy), 32'h0);
    tick(0, 0, 8'h00);

    // Restart mid-frame with a coincident byte AA.
    v0 = n_valid;
    e0 = n_err;
    tick(1, 0, 8'h00);
    for (int i = 0; i < 9; i++) tick(0, 1, 8'($urandom));
    tick(1, 1, 8'hAA);
    for (int i = 0; i < 13; i++) tick(0, 1, 8'($urandom));
    check_val("restart_ax_hi", 32'(accel_x[15:8]), 32'hAA);
    tick(0, 0, 8'h00);
    check_val("restart_err_count", 32'(n_err - e0), 32'd1);
    check_val("restart_valid_count", 32'(n_valid - v0), 32'd1);

    // Stray bytes while idle.
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 6; i++) tick(0, 1, 8'($urandom));
    check_words("stray");
    check_val("stray_pulses", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    check_val("stray_busy", 32'(busy), 32'h0);

    // Asynchronous reset after 10 bytes, then a clean frame.
    tick(1, 0, 8'h00);
    for (int i = 0; i < 10; i++) tick(0, 1, 8'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exp_tp = '{16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC, 16'hDDEE};
    tick(1, 0, 8'h00);
    for (int w = 0; w < 7; w++) begin
      tick(0, 1, exp_tp[w][15:8]);
      tick(0, 1, exp_tp[w][7:0]);
    end
    for (int w = 0; w < 7; w++) check_val($sformatf("post_reset_w%0d", w), 32'(dut_word(w)), 32'(exp_tp[w]));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      fs_r = ($urandom_range(0, 99) < 3);
      bv_r = ($urandom_range(0, 99) < 70);
      tick(fs_r, bv_r, 8'($urandom));
    end
    repeat (20) tick(0, 0, 8'h00);
    check_words("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
